banked_dual_port_sram: RTL and testbench

Parametrised simple-dual-port SRAM behavioural model: one write port, one read port, configurable mask granularity, one or two cycles of read latency, same-address read/write bypass and a post-reset clear sequencer. It replaces the single-configuration dual-port model wherever a memory must start in a known state or needs registered-output timing. The port names follow the 40 nm type T SRAM library, so a hard macro can be substituted when CLEAR_ON_RESET=0 and READ_LATENCY=1.

---
 rtl/sram_pkg.sv | 31 +++
 rtl/sram_clear_sequencer.sv | 50 +++++
 rtl/banked_dual_port_sram.sv | 157 +++++++++++++++
 tb/tb_banked_dual_port_sram.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for banked_dual_port_sram.
//   clear_state_e : state of the post-reset clear sweep
//   expand_mask   : replicates each write-mask bit across its data granule
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_e;

    // Widest data word expand_mask can serve; callers cast down to WIDTH.
    localparam int unsigned MaxWidth    = 1024;
    localparam int unsigned MaxIdxWidth = $clog2(MaxWidth);

    // Bit i of the result is mask[i / gran].
    function automatic logic [MaxWidth-1:0] expand_mask(
        input logic [MaxWidth-1:0] mask,
        input int unsigned         gran
    );
        logic [MaxWidth-1:0] expanded;
        expanded = '0;
        if (gran == 0) begin
            return mask;
        end
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            expanded[MaxIdxWidth'(i)] = mask[MaxIdxWidth'(i / gran)];
        end
        return expanded;
    endfunction

endpackage

// File: rtl/sram_clear_sequencer.sv
// Post-reset clear sweep: walks every row once, then parks in READY.
//   clk, rst_n  : clock, async active-low reset (restarts the sweep)
//   busy        : high while the sweep owns the array write port
//   sweep_addr  : row written by the sweep this cycle (valid while busy)
module sram_clear_sequencer #(
    parameter int unsigned NUM_ROWS       = 4096,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned AddressWidth  = $clog2(NUM_ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    busy,
    output logic [AddressWidth-1:0] sweep_addr
);
    import sram_pkg::*;

    clear_state_e            state_q, state_d;
    logic [AddressWidth-1:0] cnt_q, cnt_d;
    logic                    busy_q, busy_d;

    // Next state: advance one row per cycle, leave after the last row.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == AddressWidth'(NUM_ROWS - 1)) begin
                state_d = READY;
            end else begin
                cnt_d = cnt_q + AddressWidth'(1);
            end
        end
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : READY;
            cnt_q   <= '0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign sweep_addr = cnt_q;

endmodule

// File: rtl/banked_dual_port_sram.sv
// Simple-dual-port SRAM model: one masked write port, one read port with
// 1 or 2 cycles of latency, same-address bypass and a post-reset clear sweep.
//   CLK, RSTB : clock, async active-low reset
//   REB, AB   : read enable (active low), read address
//   WEB, AA   : write enable (active low), write address
//   D, M      : write data, write mask (1 = keep the stored granule)
//   Q, QV     : read data (held between reads), one-cycle read-valid pulse
//   BUSY      : clear sweep in progress, user accesses ignored
module banked_dual_port_sram #(
    parameter int unsigned      WIDTH          = 128,
    parameter int unsigned      NUM_ROWS       = 4096,
    parameter int unsigned      MASK_GRAN      = 1,
    parameter int unsigned      READ_LATENCY   = 1,
    parameter bit               BYPASS         = 1'b1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE     = '0,
    localparam int unsigned     AddressWidth   = $clog2(NUM_ROWS),
    localparam int unsigned     MaskWidth      = WIDTH / MASK_GRAN
) (
    input  logic                    CLK,
    input  logic                    RSTB,
    input  logic                    REB,
    input  logic                    WEB,
    input  logic [AddressWidth-1:0] AA,
    input  logic [AddressWidth-1:0] AB,
    input  logic [WIDTH-1:0]        D,
    input  logic [MaskWidth-1:0]    M,
    output logic [WIDTH-1:0]        Q,
    output logic                    QV,
    output logic                    BUSY
);
    import sram_pkg::*;

    // Elaboration-time parameter checks.
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (MASK_GRAN == 0 || (WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
        $error("WIDTH must be a non-zero multiple of MASK_GRAN");
    end
    if (NUM_ROWS < 2) begin : g_bad_rows
        $error("NUM_ROWS must be at least 2");
    end
    if (WIDTH > MaxWidth) begin : g_bad_width
        $error("WIDTH exceeds the mask expansion limit");
    end

    logic                    sweep_busy;
    logic [AddressWidth-1:0] sweep_addr;

    sram_clear_sequencer #(
        .NUM_ROWS       (NUM_ROWS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk        (CLK),
        .rst_n      (RSTB),
        .busy       (sweep_busy),
        .sweep_addr (sweep_addr)
    );

    // Storage is deliberately not reset; the sweep or user writes define it.
    logic [WIDTH-1:0] mem_q [NUM_ROWS];

    logic                    wr_in_range_c, rd_in_range_c;
    logic                    user_wr_c, user_rd_c;
    logic [AddressWidth-1:0] wr_idx_c, rd_idx_c;
    logic [WIDTH-1:0]        mask_exp_c, merged_c, rd_data_c;
    logic                    mem_we_c;
    logic [AddressWidth-1:0] mem_addr_c;
    logic [WIDTH-1:0]        mem_wdata_c;

    // Write merge, sweep/user write mux and read-data selection with bypass.
    always_comb begin
        wr_in_range_c = 32'(AA) < NUM_ROWS;
        rd_in_range_c = 32'(AB) < NUM_ROWS;
        user_wr_c     = !sweep_busy && !WEB && wr_in_range_c;
        user_rd_c     = !sweep_busy && !REB;
        // Clamp so out-of-range addresses never index past the array.
        wr_idx_c      = wr_in_range_c ? AA : '0;
        rd_idx_c      = rd_in_range_c ? AB : '0;
        mask_exp_c    = WIDTH'(expand_mask(MaxWidth'(M), MASK_GRAN));
        merged_c      = (D & ~mask_exp_c) | (mem_q[wr_idx_c] & mask_exp_c);

        mem_we_c      = sweep_busy || user_wr_c;
        mem_addr_c    = sweep_busy ? sweep_addr : wr_idx_c;
        mem_wdata_c   = sweep_busy ? INIT_VALUE : merged_c;

        rd_data_c     = '0;
        if (rd_in_range_c) begin
            if (BYPASS && user_wr_c && (AA == AB)) begin
                rd_data_c = merged_c;
            end else begin
                rd_data_c = mem_q[rd_idx_c];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            mem_q[mem_addr_c] <= mem_wdata_c;
        end
    end

    // Read pipeline: optional extra stage ahead of the output register.
    logic             out_vld_c;
    logic [WIDTH-1:0] out_data_c;

    if (READ_LATENCY == 2) begin : g_lat2
        logic             s1_vld_q;
        logic [WIDTH-1:0] s1_data_q;

        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                s1_vld_q  <= 1'b0;
                s1_data_q <= '0;
            end else begin
                s1_vld_q <= user_rd_c;
                if (user_rd_c) begin
                    s1_data_q <= rd_data_c;
                end
            end
        end

        assign out_vld_c  = s1_vld_q;
        assign out_data_c = s1_data_q;
    end else begin : g_lat1
        assign out_vld_c  = user_rd_c;
        assign out_data_c = rd_data_c;
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             qv_q, qv_d;

    // Q holds its last value; QV pulses only when fresh data lands.
    always_comb begin
        q_d  = q_q;
        qv_d = out_vld_c;
        if (out_vld_c) begin
            q_d = out_data_c;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            q_q  <= '0;
            qv_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            qv_q <= qv_d;
        end
    end

    assign Q    = q_q;
    assign QV   = qv_q;
    assign BUSY = sweep_busy;

endmodule

// File: tb/tb_banked_dual_port_sram.sv
// Bench for banked_dual_port_sram: two configurations driven in lockstep.
//   u0: 8 rows, latency 1, bypass on,  init 'hA5
//   u1: 6 rows, latency 2, bypass off, init 'h0
module tb_banked_dual_port_sram;

    logic        clk;
    logic        rst_n;
    logic        reb, web;
    logic [2:0]  aa, ab;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] q0, q1;
    logic        qv0, qv1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    banked_dual_port_sram #(
        .WIDTH(32), .NUM_ROWS(8), .MASK_GRAN(8), .READ_LATENCY(1),
        .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'hA5)
    ) u0 (
        .CLK(clk), .RSTB(rst_n), .REB(reb), .WEB(web), .AA(aa), .AB(ab),
        .D(d), .M(m), .Q(q0), .QV(qv0), .BUSY(busy0)
    );

    banked_dual_port_sram #(
        .WIDTH(32), .NUM_ROWS(6), .MASK_GRAN(8), .READ_LATENCY(2),
        .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'h0)
    ) u1 (
        .CLK(clk), .RSTB(rst_n), .REB(reb), .WEB(web), .AA(aa), .AB(ab),
        .D(d), .M(m), .Q(q1), .QV(qv1), .BUSY(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: rows as plain arrays, read results delayed by the latency.
    int unsigned rows     [2] = '{8, 6};
    int unsigned lat      [2] = '{1, 2};
    bit          byp      [2] = '{1'b1, 1'b0};
    logic [31:0] init_val [2] = '{32'hA5, 32'h0};

    logic [31:0] mmem [2][8];
    int unsigned sweep_left [2];
    logic        acc_v [2][4];
    logic [31:0] acc_d [2][4];
    logic [31:0] exp_q [2];
    logic        exp_qv [2];
    logic        exp_busy [2];
    int unsigned ncyc = 0;

    task automatic model_reset(input logic inst);
        sweep_left[inst] = rows[inst];
        acc_v[inst][0] = 1'b0;
        acc_v[inst][1] = 1'b0;
        acc_v[inst][2] = 1'b0;
        acc_v[inst][3] = 1'b0;
        exp_q[inst]    = 32'h0;
        exp_qv[inst]   = 1'b0;
        exp_busy[inst] = 1'b1;
    endtask

    task automatic model_step(input logic inst);
        logic [31:0] mexp, newrow, rdat;
        logic        wr, rd;
        logic [1:0]  slot, pslot;
        slot = 2'(ncyc);
        if (sweep_left[inst] != 0) begin
            mmem[inst][3'(rows[inst] - sweep_left[inst])] = init_val[inst];
            sweep_left[inst] = sweep_left[inst] - 1;
            acc_v[inst][slot] = 1'b0;
        end else begin
            mexp   = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
            wr     = !web && (32'(aa) < rows[inst]);
            rd     = !reb;
            newrow = (d & ~mexp) | (mmem[inst][aa] & mexp);
            rdat   = 32'h0;
            if (32'(ab) < rows[inst]) begin
                rdat = (wr && aa == ab && byp[inst]) ? newrow : mmem[inst][ab];
            end
            acc_v[inst][slot] = rd;
            acc_d[inst][slot] = rdat;
            if (wr) mmem[inst][aa] = newrow;
        end
        pslot = 2'(ncyc - (lat[inst] - 1));
        exp_qv[inst] = acc_v[inst][pslot];
        if (acc_v[inst][pslot]) exp_q[inst] = acc_d[inst][pslot];
        exp_busy[inst] = (sweep_left[inst] != 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(1'b0);
            model_reset(1'b1);
        end else begin
            ncyc++;
            model_step(1'b0);
            model_step(1'b1);
        end
    end

    // Every cycle, both instances against the model.
    always @(negedge clk) begin
        chk("mdl_q0",    q0,           exp_q[0]);
        chk("mdl_qv0",   32'(qv0),     32'(exp_qv[0]));
        chk("mdl_busy0", 32'(busy0),   32'(exp_busy[0]));
        chk("mdl_q1",    q1,           exp_q[1]);
        chk("mdl_qv1",   32'(qv1),     32'(exp_qv[1]));
        chk("mdl_busy1", 32'(busy1),   32'(exp_busy[1]));
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  aa;
        logic [2:0]  ab;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] q0;
        logic        qv0;
        logic [31:0] q1;
        logic        qv1;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] a_w,
                                input logic [2:0] a_r, input logic [31:0] dd, input logic [3:0] mm,
                                input logic [31:0] e_q0, input logic e_qv0,
                                input logic [31:0] e_q1, input logic e_qv1);
        vec_t v;
        v.rd = rd; v.wr = wr; v.aa = a_w; v.ab = a_r; v.d = dd; v.m = mm;
        v.q0 = e_q0; v.qv0 = e_qv0; v.q1 = e_q1; v.qv1 = e_qv1;
        return v;
    endfunction

    task automatic drive_idle();
        reb = 1'b1; web = 1'b1; aa = 3'd0; ab = 3'd0; d = 32'h0; m = 4'h0;
    endtask

    // Counts cycles with BUSY high starting at the current (post-release) point.
    task automatic busy_len(input string tag, input bit poke_during_busy);
        int n0, n1;
        n0 = 0; n1 = 0;
        for (int it = 0; it < 21; it++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            if (poke_during_busy && it == 4) begin
                web = 1'b0; aa = 3'd1; d = 32'hDEADBEEF; m = 4'h0;
                reb = 1'b0; ab = 3'd1;
            end else begin
                drive_idle();
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, "_len0"}, 32'(n0), 32'd8);
        chk({tag, "_len1"}, 32'(n1), 32'd6);
    endtask

    vec_t tbl [18];

    initial begin
        tbl[0]  = mk(0, 1, 3, 0, 32'h11223344, 4'h0, 32'h0,        0, 32'h0,        0);
        tbl[1]  = mk(0, 1, 3, 0, 32'hFFFFFFFF, 4'h5, 32'h0,        0, 32'h0,        0);
        tbl[2]  = mk(1, 0, 0, 3, 32'h0,        4'h0, 32'hFF22FF44, 1, 32'h0,        0);
        tbl[3]  = mk(1, 1, 2, 2, 32'h5,        4'h0, 32'h5,        1, 32'hFF22FF44, 1);
        tbl[4]  = mk(1, 0, 0, 2, 32'h0,        4'h0, 32'h5,        1, 32'h0,        1);
        tbl[5]  = mk(1, 0, 0, 0, 32'h0,        4'h0, 32'hA5,       1, 32'h5,        1);
        tbl[6]  = mk(1, 0, 0, 1, 32'h0,        4'h0, 32'hA5,       1, 32'h0,        1);
        tbl[7]  = mk(1, 0, 0, 2, 32'h0,        4'h0, 32'h5,        1, 32'h0,        1);
        tbl[8]  = mk(1, 0, 0, 7, 32'h0,        4'h0, 32'hA5,       1, 32'h5,        1);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,        4'h0, 32'hA5,       0, 32'h0,        1);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,        4'h0, 32'hA5,       0, 32'h0,        0);
        tbl[11] = mk(0, 1, 7, 0, 32'h77,       4'h0, 32'hA5,       0, 32'h0,        0);
        tbl[12] = mk(1, 0, 0, 7, 32'h0,        4'h0, 32'h77,       1, 32'h0,        0);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,        4'h0, 32'h77,       0, 32'h0,        1);
        tbl[14] = mk(0, 1, 4, 0, 32'hAAAA,     4'h0, 32'h77,       0, 32'h0,        0);
        tbl[15] = mk(1, 1, 4, 4, 32'hBBBB,     4'hE, 32'hAABB,     1, 32'h0,        0);
        tbl[16] = mk(0, 0, 0, 0, 32'h0,        4'h0, 32'hAABB,     0, 32'hAAAA,     1);
        tbl[17] = mk(0, 0, 0, 0, 32'h0,        4'h0, 32'hAABB,     0, 32'hAAAA,     0);

        rst_n = 1'b0;
        drive_idle();

        // Reset values.
        @(negedge clk);
        chk("rst_q0", q0, 32'h0);
        chk("rst_qv0", 32'(qv0), 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h1);
        chk("rst_q1", q1, 32'h0);
        chk("rst_qv1", 32'(qv1), 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h1);

        // Sweep length, with a write and read poked in while BUSY.
        @(negedge clk);
        #2 rst_n = 1'b1;
        busy_len("sweep", 1'b1);

        // Directed vectors: masks, collisions, latency, out-of-range.
        for (int j = 0; j < 18; j++) begin
            reb = !tbl[j].rd; web = !tbl[j].wr;
            aa = tbl[j].aa; ab = tbl[j].ab; d = tbl[j].d; m = tbl[j].m;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_q0", j), q0, tbl[j].q0);
            chk($sformatf("tbl%0d_qv0", j), 32'(qv0), 32'(tbl[j].qv0));
            chk($sformatf("tbl%0d_q1", j), q1, tbl[j].q1);
            chk($sformatf("tbl%0d_qv1", j), 32'(qv1), 32'(tbl[j].qv1));
        end
        drive_idle();

        // Reset in the middle of a read flushes the pipeline.
        reb = 1'b0; ab = 3'd4;
        @(posedge clk);
        #1 reb = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("midrd_q0", q0, 32'h0);
        chk("midrd_qv0", 32'(qv0), 32'h0);
        chk("midrd_q1", q1, 32'h0);
        chk("midrd_qv1", 32'(qv1), 32'h0);
        chk("midrd_busy0", 32'(busy0), 32'h1);
        chk("midrd_busy1", 32'(busy1), 32'h1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // One-cycle reset at sweep row 5 restarts a full-length sweep.
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        busy_len("resweep", 1'b0);

        // Random traffic against the model.
        repeat (500) begin
            reb = ($urandom_range(0, 1) == 0);
            web = ($urandom_range(0, 1) == 0);
            aa  = 3'($urandom_range(0, 7));
            ab  = 3'($urandom_range(0, 7));
            d   = $urandom;
            m   = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        drive_idle();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
